// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit: radix-2 shift-add multiply, restoring
// divide, HI/LO registers with MTHI/MTLO writes and a flush abort.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Abort,
  input  logic             HiWe,
  input  logic             LoWe,
  input  logic [WIDTH-1:0] WData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  // Multiply: {partial product, multiplier}. Divide: {remainder, dividend -> quotient}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div, div_zero, neg_q, neg_r;

  logic               sign_a, sign_b, b_zero, div_fits;
  logic [WIDTH-1:0]   a_mag, b_mag, div_rem, quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum, div_part;
  logic [2*WIDTH-1:0] acc_next, prod_fix;

  always_comb begin
    sign_a   = Op[0] & A[WIDTH-1];
    sign_b   = Op[0] & B[WIDTH-1];
    a_mag    = sign_a ? -A : A;
    b_mag    = sign_b ? -B : B;
    b_zero   = (B == '0);
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_part = acc[2*WIDTH-1:WIDTH-1];
    div_fits = (div_part >= {1'b0, opnd});
    div_rem  = WIDTH'(div_part - {1'b0, opnd});
    if (!is_div)       acc_next = {mul_sum, acc[WIDTH-1:1]};
    else if (div_fits) acc_next = {div_rem, acc[WIDTH-2:0], 1'b1};
    else               acc_next = {acc[2*WIDTH-2:0], 1'b0};
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      DivZero  <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      case (state)
        IDLE: begin
          if (HiWe) Hi <= WData;
          if (LoWe) Lo <= WData;
          if (Start && !Abort) begin
            is_div   <= Op[1];
            div_zero <= Op[1] & b_zero;
            neg_q    <= sign_a ^ sign_b;
            neg_r    <= sign_a;
            opnd     <= Op[1] ? b_mag : a_mag;
            acc      <= {{WIDTH{1'b0}}, (Op[1] ? a_mag : b_mag)};
            count    <= CW'(WIDTH);
            Busy     <= 1'b1;
            state    <= (Op[1] && b_zero) ? FIN : RUN;
          end
        end
        RUN: begin
          if (Abort) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            acc   <= acc_next;
            count <= count - CW'(1);
            if (count == CW'(1)) state <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
          Busy  <= 1'b0;
          if (!Abort) begin
            Done    <= 1'b1;
            DivZero <= div_zero;
            if (!div_zero) begin
              if (is_div) begin
                Hi <= rem_fix;
                Lo <= quo_fix;
              end else begin
                {Hi, Lo} <= prod_fix;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
